// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one pipelined unsigned multiplier among NREQ
// requesters; results return in acceptance order, tagged with the requester ID.
module mult_share_sched #(
    parameter int unsigned BITS = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned LAT  = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*BITS-1:0]   req_a,
    input  logic [NREQ*BITS-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    output logic [IDW-1:0]         res_id,
    output logic [2*BITS-1:0]      res_data,
    output logic                   busy,
    output logic [15:0]            op_count
);

    logic [IDW-1:0]    r_ptr;
    logic [LAT-1:0]    r_vld;
    logic [IDW-1:0]    r_id   [LAT];
    logic [2*BITS-1:0] r_prod [LAT];
    logic              r_res_valid;
    logic [IDW-1:0]    r_res_id;
    logic [2*BITS-1:0] r_res_data;
    logic [15:0]       r_cnt;

    logic [NREQ-1:0]   w_grant;
    logic              w_any;
    logic [IDW-1:0]    w_sel;
    logic [BITS-1:0]   w_a;
    logic [BITS-1:0]   w_b;
    logic [2*BITS-1:0] w_prod;

    function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base,
                                              input int unsigned   off);
        int unsigned sum;
        sum = 32'(base) + off;
        return IDW'(sum % NREQ);
    endfunction

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_sel   = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            if (!w_any && req_valid[f_wrap(r_ptr, off)]) begin
                w_any = 1'b1;
                w_sel = f_wrap(r_ptr, off);
            end
        end
        if (w_any) w_grant[w_sel] = 1'b1;
    end

    assign req_ready = reset_n ? w_grant : '0;

    assign w_a    = req_a[32'(w_sel)*BITS +: BITS];
    assign w_b    = req_b[32'(w_sel)*BITS +: BITS];
    assign w_prod = {{BITS{1'b0}}, w_a} * {{BITS{1'b0}}, w_b};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_vld       <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_cnt       <= '0;
            for (int unsigned s = 0; s < LAT; s++) begin
                r_id[s]   <= '0;
                r_prod[s] <= '0;
            end
        end else begin
            if (w_any) r_ptr <= f_wrap(w_sel, 1);
            r_vld[0]  <= w_any;
            r_id[0]   <= w_sel;
            r_prod[0] <= w_prod;
            for (int unsigned s = 1; s < LAT; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_id[s]   <= r_id[s-1];
                r_prod[s] <= r_prod[s-1];
            end
            // Output register only reloads on a valid op so id/data hold between results.
            r_res_valid <= r_vld[LAT-1];
            if (r_vld[LAT-1]) begin
                r_res_id   <= r_id[LAT-1];
                r_res_data <= r_prod[LAT-1];
            end
            if (r_res_valid) r_cnt <= r_cnt + 16'd1;
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_data  = r_res_data;
    assign busy      = |r_vld;
    assign op_count  = r_cnt;

endmodule

// File: tb/tb_mult_share_sched.sv
// Randomized and directed bench for mult_share_sched against a queue-based
// transaction model of arbitration, latency and result ordering.
module tb_mult_share_sched;

    localparam int BITS = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 2;

    logic                 clock   = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*BITS-1:0] req_a = '0;
    logic [NREQ*BITS-1:0] req_b = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [2*BITS-1:0]    res_data;
    logic                 busy;
    logic [15:0]          op_count;

    mult_share_sched #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int due;
        int id;
        int p;
    } res_t;

    res_t            q[$];
    int              m_ptr  = 0;
    logic            m_rv   = 1'b0;
    logic [IDW-1:0]  m_id   = '0;
    logic [15:0]     m_data = '0;
    logic [15:0]     m_cnt  = '0;
    logic            m_busy = 1'b0;
    int              edge_n = 0;

    logic [NREQ-1:0] v = '0;
    logic [BITS-1:0] av[NREQ];
    logic [BITS-1:0] bv[NREQ];

    function automatic int pick(input int p, input logic [NREQ-1:0] vv);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (vv[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [BITS-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return BITS'($urandom);
        endcase
    endfunction

    task automatic drive();
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*BITS +: BITS] = av[i];
            req_b[i*BITS +: BITS] = bv[i];
        end
    endtask

    // One clock: check at negedge, then advance the model across the posedge.
    task automatic cycle();
        int g;
        int prod;
        logic [NREQ-1:0] er;
        drive();
        @(negedge clock);
        g  = pick(m_ptr, req_valid);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        prod = (g >= 0) ? int'(av[g]) * int'(bv[g]) : 0;
        check("req_ready", 32'(req_ready), 32'(er));
        check("res_valid", 32'(res_valid), 32'(m_rv));
        check("res_id",    32'(res_id),    32'(m_id));
        check("res_data",  32'(res_data),  32'(m_data));
        check("busy",      32'(busy),      32'(m_busy));
        check("op_count",  32'(op_count),  32'(m_cnt));
        @(posedge clock);
        edge_n++;
        if (g >= 0) begin
            q.push_back('{due: edge_n + LAT, id: g, p: prod});
            m_ptr = (g + 1) % NREQ;
            v[g]  = 1'b0;
        end
        m_cnt = m_cnt + 16'(m_rv);
        if (q.size() != 0 && q[0].due == edge_n) begin
            m_rv   = 1'b1;
            m_id   = IDW'(q[0].id);
            m_data = 16'(q[0].p);
            void'(q.pop_front());
        end else begin
            m_rv = 1'b0;
        end
        m_busy = (q.size() != 0);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        m_ptr  = 0;
        m_rv   = 1'b0;
        m_id   = '0;
        m_data = '0;
        m_cnt  = '0;
        m_busy = 1'b0;
        drive();
        #1;
        check("rst_ready",     32'(req_ready), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_res_id",    32'(res_id),    32'(0));
        check("rst_res_data",  32'(res_data),  32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_op_count",  32'(op_count),  32'(0));
        @(posedge clock);
        edge_n++;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        #2;
        v = 4'b1111;
        do_reset();

        // Single op from requester 1
        v = '0;
        v[1] = 1'b1; av[1] = 8'd12; bv[1] = 8'd10;
        cycle(); cycle(); cycle();
        check("single_valid", 32'(res_valid), 32'(1));
        check("single_id",    32'(res_id),    32'(1));
        check("single_data",  32'(res_data),  32'(120));
        check("single_busy",  32'(busy),      32'(0));
        cycle();
        check("single_count", 32'(op_count),  32'(1));
        check("single_hold",  32'(res_data),  32'(120));

        // Fairness with all requesters valid
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            av[i] = BITS'(i + 1);
            bv[i] = 8'd3;
        end
        for (int n = 0; n < 8; n++) begin
            v = '1;
            cycle();
        end
        v = '0;
        for (int n = 0; n < 4; n++) cycle();

        // Pointer rotation: after granting 2, ptr=3 wraps to 0 before 2
        do_reset();
        v = 4'b0100; av[2] = rnd_op(); bv[2] = rnd_op();
        cycle();
        v = 4'b0101; av[0] = rnd_op();
        drive();
        #1;
        check("rot_ready", 32'(req_ready), 32'(4'b0001));
        cycle();
        for (int n = 0; n < 5; n++) cycle();

        // Maximum operands
        v = 4'b0001; av[0] = 8'hFF; bv[0] = 8'hFF;
        cycle(); cycle(); cycle();
        check("max_data", 32'(res_data), 32'(16'hFE01));
        check("max_id",   32'(res_id),   32'(0));
        cycle();

        // Reset with two ops in flight
        v = 4'b0011;
        av[0] = rnd_op(); bv[0] = rnd_op();
        av[1] = rnd_op(); bv[1] = rnd_op();
        cycle(); cycle();
        check("mid_busy_pre", 32'(busy), 32'(1));
        do_reset();
        for (int n = 0; n < 4; n++) cycle();
        check("mid_busy",  32'(busy),     32'(0));
        check("mid_count", 32'(op_count), 32'(0));
        v = '1;
        drive();
        #1;
        check("mid_ptr0", 32'(req_ready), 32'(4'b0001));
        v = '0;
        cycle();

        // Random traffic with hold-until-transfer requesters
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        v[i]  = 1'b1;
                        av[i] = rnd_op();
                        bv[i] = rnd_op();
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;
                end
            end
            cycle();
        end
        v = '0;
        for (int n = 0; n < 4; n++) cycle();

        // Counter wrap over 65536 back-to-back ops
        do_reset();
        for (int n = 0; n < 65536; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i]) begin
                    av[i] = rnd_op();
                    bv[i] = rnd_op();
                end
            end
            v = '1;
            cycle();
        end
        v = '0;
        for (int n = 0; n < 4; n++) cycle();
        check("wrap_count", 32'(op_count), 32'(0));
        check("wrap_busy",  32'(busy),     32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
